// File: rtl/uart_protocol_rx.sv
// Frame parser: HEAD, PAYLOAD_LEN payload bytes, CRC-8/0x07, TAIL -> rev_data1..10 with a recv_done pulse.
// Optional macro UART_PROTOCOL_RX_CRC_CHECK_EN enables the CRC comparison and the crc_err pulse.
module uart_protocol_rx #(
  parameter logic [7:0] HEAD_BYTE   = 8'h80,
  parameter logic [7:0] TAIL_BYTE   = 8'h55,
  parameter int         PAYLOAD_LEN = 3,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  output logic       recv_done,
  output logic [7:0] rev_data1,
  output logic [7:0] rev_data2,
  output logic [7:0] rev_data3,
  output logic [7:0] rev_data4,
  output logic [7:0] rev_data5,
  output logic [7:0] rev_data6,
  output logic [7:0] rev_data7,
  output logic [7:0] rev_data8,
  output logic [7:0] rev_data9,
  output logic [7:0] rev_data10,
  output logic       frame_err,
  output logic       crc_err,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  // uart_rx_done is a valid-only strobe with no ready: every strobed byte is consumed
  // in the cycle it is presented, so a strobe held high delivers one byte per cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAYLOAD = 2'd1, S_CRC = 2'd2, S_TAIL = 2'd3} state_t;

  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_LEN - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [3:0]      r_idx;
  logic [7:0]      r_shadow [PAYLOAD_LEN];
  logic [7:0]      r_rev    [10];
  logic            r_recv_done;
  logic            r_frame_err;
  logic            w_timeout;
  logic            w_tail_seen;
  logic            w_accept_nxt;
  logic            w_ferr_nxt;
  logic            w_crc_ok;
  logic            w_head_seen;
  logic            w_payload_byte;

  assign w_head_seen    = (r_state == S_IDLE) && uart_rx_done && (uart_rx_data == HEAD_BYTE);
  assign w_payload_byte = (r_state == S_PAYLOAD) && uart_rx_done;
  // A strobe in the timeout cycle wins: the byte is processed instead.
  assign w_timeout = (r_state != S_IDLE) && !uart_rx_done && (r_timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_50M) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (uart_rx_done) begin
      case (r_state)
        S_IDLE:    if (uart_rx_data == HEAD_BYTE) w_state_nxt = S_PAYLOAD;
        S_PAYLOAD: if (r_idx == LAST_IDX) w_state_nxt = S_CRC;
        S_CRC:     w_state_nxt = S_TAIL;
        S_TAIL:    w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tail_seen  = (r_state == S_TAIL) && uart_rx_done;
    w_accept_nxt = w_tail_seen && (uart_rx_data == TAIL_BYTE) && w_crc_ok;
    w_ferr_nxt   = (w_tail_seen && (uart_rx_data != TAIL_BYTE)) || w_timeout;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n || uart_rx_done || (r_state == S_IDLE) || w_timeout) r_timer <= '0;
    else                                                             r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_recv_done <= 1'b0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < PAYLOAD_LEN; k++) r_shadow[k] <= '0;
      for (int k = 0; k < 10; k++) r_rev[k] <= '0;
    end else begin
      r_recv_done <= w_accept_nxt;
      r_frame_err <= w_ferr_nxt;
      if (w_head_seen)         r_idx <= '0;
      else if (w_payload_byte) r_idx <= r_idx + 1'b1;
      for (int k = 0; k < PAYLOAD_LEN; k++)
        if (w_payload_byte && (r_idx == 4'(k))) r_shadow[k] <= uart_rx_data;
      // Entries at or above PAYLOAD_LEN are never written and stay at their reset value 0.
      if (w_accept_nxt)
        for (int k = 0; k < PAYLOAD_LEN; k++) r_rev[k] <= r_shadow[k];
    end
  end

`ifdef UART_PROTOCOL_RX_CRC_CHECK_EN
  logic [7:0] r_crc;
  logic [7:0] r_rx_crc;
  logic       r_crc_err;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign w_crc_ok = (r_crc == r_rx_crc);

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      r_crc     <= '0;
      r_rx_crc  <= '0;
      r_crc_err <= 1'b0;
    end else begin
      r_crc_err <= w_tail_seen && (uart_rx_data == TAIL_BYTE) && !w_crc_ok;
      if (w_head_seen)         r_crc <= '0;
      else if (w_payload_byte) r_crc <= crc8_byte(r_crc, uart_rx_data);
      if ((r_state == S_CRC) && uart_rx_done) r_rx_crc <= uart_rx_data;
    end
  end

  assign crc_err = r_crc_err;
`else
  assign w_crc_ok = 1'b1;
  assign crc_err  = 1'b0;
`endif

  assign recv_done   = r_recv_done;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
  assign rev_data1   = r_rev[0];
  assign rev_data2   = r_rev[1];
  assign rev_data3   = r_rev[2];
  assign rev_data4   = r_rev[3];
  assign rev_data5   = r_rev[4];
  assign rev_data6   = r_rev[5];
  assign rev_data7   = r_rev[6];
  assign rev_data8   = r_rev[7];
  assign rev_data9   = r_rev[8];
  assign rev_data10  = r_rev[9];

endmodule

// File: tb/tb_uart_protocol_rx.sv
// Bench for uart_protocol_rx: frames are built at byte level, expected pulses and
// rev_data contents are queued from the frame-level rules and checked by a monitor.
module tb_uart_protocol_rx;

  localparam int         LEN  = 3;
  localparam int         TO   = 200;
  localparam int         W    = 82;
  localparam logic [7:0] HEAD = 8'h80;
  localparam logic [7:0] TAIL = 8'h55;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_FERR = 2'd2;
  localparam logic [1:0] EV_CERR = 2'd3;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx_done = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       recv_done, frame_err, crc_err, busy;
  logic [7:0] rev_data1, rev_data2, rev_data3, rev_data4, rev_data5;
  logic [7:0] rev_data6, rev_data7, rev_data8, rev_data9, rev_data10;
  logic [1:0] o_dbg_state;
  logic [79:0] w_rev;

  logic [W-1:0] exp_q[$];
  logic [79:0]  last_good = '0;
  int           n_checks = 0;
  int           n_pass = 0;
  logic [1:0]   mon_ev;
  logic [W-1:0] mon_exp;
  logic [7:0]   pl[$];

  uart_protocol_rx #(.PAYLOAD_LEN(LEN), .TIMEOUT_CYC(TO)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
    .recv_done(recv_done),
    .rev_data1(rev_data1), .rev_data2(rev_data2), .rev_data3(rev_data3), .rev_data4(rev_data4),
    .rev_data5(rev_data5), .rev_data6(rev_data6), .rev_data7(rev_data7), .rev_data8(rev_data8),
    .rev_data9(rev_data9), .rev_data10(rev_data10),
    .frame_err(frame_err), .crc_err(crc_err), .busy(busy), .o_dbg_state(o_dbg_state)
  );

  assign w_rev = {rev_data10, rev_data9, rev_data8, rev_data7, rev_data6,
                  rev_data5, rev_data4, rev_data3, rev_data2, rev_data1};

  always #10 clk_50M = ~clk_50M;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, expected %0d entries left", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // CRC as polynomial division of message * x^8 by x^8+x^2+x+1.
  function automatic logic [7:0] crc8_model(input logic [7:0] msg[$]);
    logic [8:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i <= msg.size(); i++) begin
      b = (i < msg.size()) ? msg[i] : 8'h00;
      for (int j = 7; j >= 0; j--) begin
        r = {r[7:0], b[j]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0:       return HEAD;
      1:       return TAIL;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: every pulse must match the next queued event, with rev_data as expected.
  always @(posedge clk_50M) begin
    #1;
    if (rst_n && (recv_done || frame_err || crc_err)) begin
      mon_ev = recv_done ? EV_DONE : (frame_err ? EV_FERR : EV_CERR);
      check("one_pulse", W'($countones({recv_done, frame_err, crc_err})), W'(1));
      check("busy_at_pulse", W'(busy), W'(0));
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {mon_ev, w_rev}, '0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", {mon_ev, w_rev}, mon_exp);
      end
    end
  end

  task automatic send_stream(input logic [7:0] b[$], input int gmax);
    int g;
    foreach (b[i]) begin
      @(negedge clk_50M);
      uart_rx_done = 1'b1;
      uart_rx_data = b[i];
      g = $urandom_range(0, gmax);
      if (g > 0) begin
        @(negedge clk_50M);
        uart_rx_done = 1'b0;
        repeat (g - 1) @(negedge clk_50M);
      end
    end
    @(negedge clk_50M);
    uart_rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] p[$], input logic [7:0] crc_xor, input logic [7:0] tail);
    logic [7:0]  fr[$];
    logic [79:0] np;
    np = '0;
    fr.push_back(HEAD);
    foreach (p[i]) begin
      fr.push_back(p[i]);
      np[8*i +: 8] = p[i];
    end
    fr.push_back(crc8_model(p) ^ crc_xor);
    fr.push_back(tail);
    if (tail != TAIL) begin
      exp_q.push_back({EV_FERR, last_good});
    end else if (crc_xor != 8'h00) begin
`ifdef UART_PROTOCOL_RX_CRC_CHECK_EN
      exp_q.push_back({EV_CERR, last_good});
`else
      exp_q.push_back({EV_DONE, np});
      last_good = np;
`endif
    end else begin
      exp_q.push_back({EV_DONE, np});
      last_good = np;
    end
    send_stream(fr, 3);
    repeat (2) @(negedge clk_50M);
  endtask

  task automatic send_truncated(input logic [7:0] p[$], input int keep);
    logic [7:0] fr[$];
    logic [7:0] full[$];
    full.push_back(HEAD);
    foreach (p[i]) full.push_back(p[i]);
    full.push_back(crc8_model(p));
    for (int i = 0; i < keep; i++) fr.push_back(full[i]);
    exp_q.push_back({EV_FERR, last_good});
    send_stream(fr, 3);
    repeat (TO + 10) @(negedge clk_50M);
  endtask

  task automatic rand_payload();
    pl.delete();
    for (int i = 0; i < LEN; i++) pl.push_back(rand_byte());
  endtask

  task automatic set_payload(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pl.delete();
    pl.push_back(a);
    pl.push_back(b);
    pl.push_back(c);
  endtask

  initial begin
    int cnt;
    int kind;
    logic [7:0] t;
    logic [7:0] junk[$];

    repeat (3) @(negedge clk_50M);
    check("reset_outputs", W'({recv_done, frame_err, crc_err, busy, w_rev}), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    // Good frame 12 34 56; then same frame with corrupted CRC.
    set_payload(8'h12, 8'h34, 8'h56);
    send_frame(pl, 8'h00, TAIL);
    check("t1_rev123", W'(w_rev[23:0]), W'(24'h563412));
    check("t1_rev_hi", W'(w_rev[79:24]), '0);
    send_frame(pl, 8'h01, TAIL);
    check("t2_rev123", W'(w_rev[23:0]), W'(24'h563412));

    // Bad tail, then a good frame.
    set_payload(8'hAA, 8'hBB, 8'hCC);
    send_frame(pl, 8'h00, 8'h77);
    check("t3_busy", W'(busy), '0);
    set_payload(8'h01, 8'h02, 8'h03);
    send_frame(pl, 8'h00, TAIL);
    check("t3_accept", W'(w_rev[23:0]), W'(24'h030201));

    // Leading junk bytes are ignored.
    junk.delete();
    junk.push_back(8'h00);
    junk.push_back(8'hFF);
    junk.push_back(8'h55);
    foreach (junk[i]) begin
      @(negedge clk_50M);
      uart_rx_done = 1'b1;
      uart_rx_data = junk[i];
      @(negedge clk_50M);
      uart_rx_done = 1'b0;
      check("t4_busy_junk", W'(busy), '0);
    end
    set_payload(8'h9A, 8'hBC, 8'hDE);
    send_frame(pl, 8'h00, TAIL);

    // Timeout latency after the last strobe.
    exp_q.push_back({EV_FERR, last_good});
    @(negedge clk_50M);
    uart_rx_done = 1'b1;
    uart_rx_data = HEAD;
    @(negedge clk_50M);
    uart_rx_data = 8'h11;
    @(negedge clk_50M);
    uart_rx_data = 8'h22;
    @(posedge clk_50M);
    #1;
    uart_rx_done = 1'b0;
    cnt = 0;
    while (cnt < TO + 20) begin
      @(posedge clk_50M);
      cnt++;
      #1;
      if (frame_err) break;
    end
    check("t5_latency", W'(cnt), W'(TO));
    check("t5_state_idle", W'(o_dbg_state), '0);
    check("t5_rev_kept", W'(w_rev), W'(last_good));
    repeat (3) @(negedge clk_50M);

    // Reset mid-frame.
    junk.delete();
    junk.push_back(HEAD);
    junk.push_back(8'h11);
    send_stream(junk, 1);
    rst_n = 1'b0;
    @(negedge clk_50M);
    rst_n = 1'b1;
    check("t6_busy", W'(busy), '0);
    check("t6_rev_zero", W'(w_rev), '0);
    last_good = '0;
    set_payload(8'h42, 8'h80, 8'h55);
    send_frame(pl, 8'h00, TAIL);

    // Randomized frame mix.
    for (int n = 0; n < 60; n++) begin
      rand_payload();
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        send_frame(pl, 8'h00, TAIL);
      end else if (kind <= 6) begin
        send_frame(pl, 8'h01 << $urandom_range(0, 7), TAIL);
      end else if (kind <= 8) begin
        t = ($urandom_range(0, 2) == 0) ? HEAD : 8'($urandom_range(0, 255));
        if (t == TAIL) t = 8'h00;
        send_frame(pl, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h10, t);
      end else begin
        send_truncated(pl, $urandom_range(1, LEN + 2));
      end
      junk.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        t = 8'($urandom_range(0, 255));
        if (t == HEAD) t = 8'h81;
        junk.push_back(t);
      end
      if (junk.size() > 0) send_stream(junk, 2);
    end

    repeat (10) @(negedge clk_50M);
    check("queue_drained", W'(exp_q.size()), '0);
    check("final_rev", W'(w_rev), W'(last_good));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
